// File: rtl/div_by_sub.sv
// rtl/div_by_sub.sv - unsigned divider by repeated subtraction; optional DIV_SHORTCUT_EN finishes divide-by-one on the first SUB cycle
module div_by_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_SUB    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
`ifdef DIV_SHORTCUT_EN
    logic             r_first;
`endif

    // Control FSM with registered quotient/remainder/divisor and status outputs.
    // quotient and remainder are the live Q and R registers, so they hold
    // their final values until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SHORTCUT_EN
            r_first     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        remainder   <= data_in;
                        quotient    <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    r_d     <= data_in;
`ifdef DIV_SHORTCUT_EN
                    r_first <= 1'b1;
`endif
                    r_state <= S_SUB;
                end
                S_SUB: begin
`ifdef DIV_SHORTCUT_EN
                    r_first <= 1'b0;
`endif
                    if (r_d == '0) begin
                        // Divide by zero: saturate Q, leave the dividend in R.
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
`ifdef DIV_SHORTCUT_EN
                    end else if (r_first && (r_d == WIDTH'(1))) begin
                        // Divisor of one: the answer is the dividend itself.
                        quotient  <= remainder;
                        remainder <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end else if (remainder >= r_d) begin
                        remainder <= remainder - r_d;
                        quotient  <= quotient + WIDTH'(1);
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Start is not accepted here; it is taken in the next IDLE cycle.
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_by_sub.sv
// tb/tb_div_by_sub.sv - directed self-checking bench for div_by_sub
module tb_div_by_sub;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    div_by_sub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One operation: start with dividend a in T0, divisor b in T1, optional
    // stray start in cycle inj_cyc, then expect done exactly at T0+exp_lat.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_cyc, input logic [W-1:0] inj_val,
                          input int exp_lat, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
        int cyc;
        int got;
        int busy_cnt;
        logic busy_at_done;
        logic [W-1:0] q_at;
        logic [W-1:0] r_at;
        logic dz_at;
        got = 0;
        busy_cnt = 0;
        busy_at_done = 1'bx;
        q_at = 'x;
        r_at = 'x;
        dz_at = 1'bx;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (got == 0 && cyc <= exp_lat + 20) begin
            data_in = (cyc == 1) ? b : 16'hA5C3;
            start   = 1'b0;
            if (cyc == inj_cyc) begin
                start   = 1'b1;
                data_in = inj_val;
            end
            if (done) begin
                got          = cyc;
                busy_at_done = busy;
                q_at         = quotient;
                r_at         = remainder;
                dz_at        = div_by_zero;
            end else begin
                if (busy) busy_cnt++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({name, " latency"}, got, exp_lat);
        check({name, " quotient"}, q_at, eq);
        check({name, " remainder"}, r_at, er);
        check({name, " div_by_zero"}, dz_at, edz);
        check({name, " busy at done"}, busy_at_done, 1'b0);
        check({name, " busy cycles"}, busy_cnt, exp_lat - 1);
        @(posedge clk);
        @(negedge clk);
        check({name, " done one cycle"}, done, 1'b0);
        check({name, " quotient held"}, quotient, eq);
        check({name, " remainder held"}, remainder, er);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #3;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 16'h0);
        check("reset remainder", remainder, 16'h0);
        check("reset div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("17/5", 16'd17, 16'd5, 0, 16'd0, 6, 16'd3, 16'd2, 1'b0);
        run_op("0/7", 16'd0, 16'd7, 0, 16'd0, 3, 16'd0, 16'd0, 1'b0);
        run_op("9/0", 16'd9, 16'd0, 0, 16'd0, 3, 16'hFFFF, 16'd9, 1'b1);
        run_op("20/4 stray start", 16'd20, 16'd4, 3, 16'd99, 8, 16'd5, 16'd0, 1'b0);
        run_op("7/9", 16'd7, 16'd9, 0, 16'd0, 3, 16'd0, 16'd7, 1'b0);

        // Abort 100/3 with reset at T0+10.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd3;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort busy before rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort quotient", quotient, 16'h0);
        check("abort remainder", remainder, 16'h0);
        check("abort div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("abort no done", done, 1'b0);
            check("abort stays idle", busy, 1'b0);
        end
        run_op("8/8 after abort", 16'd8, 16'd8, 0, 16'd0, 4, 16'd1, 16'd0, 1'b0);

`ifdef DIV_SHORTCUT_EN
        run_op("65535/1", 16'hFFFF, 16'd1, 0, 16'd0, 3, 16'hFFFF, 16'd0, 1'b0);
        run_op("5/1", 16'd5, 16'd1, 0, 16'd0, 3, 16'd5, 16'd0, 1'b0);
`else
        run_op("65535/1", 16'hFFFF, 16'd1, 0, 16'd0, 65538, 16'hFFFF, 16'd0, 1'b0);
        run_op("5/1", 16'd5, 16'd1, 0, 16'd0, 8, 16'd5, 16'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
